// File: rtl/vga_color_fade.sv
// vga_color_fade: final colour stage in front of the VGA DAC pins.
// Applies a per-pixel colour mode, blanks outside the visible area and scales
// the colour by a brightness level that a frame-synchronous fade FSM ramps.
//
// Ports:
//   clk          pixel clock
//   RST          synchronous, active-low reset
//   vga_out      pixel colour {R,G,B}, CH_W bits per channel
//   active       1 = pixel is inside the visible area
//   mode         00 direct, 01 grayscale, 10 invert, 11 swap R/B
//   vsync_pulse  one-cycle strobe at each frame start
//   fade_in      one-cycle request to ramp the level up to full brightness
//   fade_out     one-cycle request to ramp the level down to zero
//   VGA_R/G/B    registered colour outputs, two cycles after vga_out
//   level        current brightness level
//   fade_busy    1 while a fade is in progress
module vga_color_fade #(
  parameter int CH_W        = 4,
  parameter int BRIGHT_W    = 4,
  parameter int FADE_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [3*CH_W-1:0]     vga_out,
  input  logic                  active,
  input  logic [1:0]            mode,
  input  logic                  vsync_pulse,
  input  logic                  fade_in,
  input  logic                  fade_out,
  output logic [CH_W-1:0]       VGA_R,
  output logic [CH_W-1:0]       VGA_G,
  output logic [CH_W-1:0]       VGA_B,
  output logic [BRIGHT_W-1:0]   level,
  output logic                  fade_busy
);

  localparam int                  PIX_W    = 3 * CH_W;
  localparam int                  PROD_W   = CH_W + BRIGHT_W + 1;
  localparam int                  CNT_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [BRIGHT_W-1:0] LMAX     = '1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_ON       = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_OFF      = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_t;

  // Luma approximation (R + 2G + B) / 4; the sum needs two extra bits.
  function automatic logic [CH_W-1:0] gray_f(input logic [CH_W-1:0] r,
                                              input logic [CH_W-1:0] g,
                                              input logic [CH_W-1:0] b);
    logic [CH_W+1:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[CH_W+1:2];
  endfunction

  // Brightness scaling c*(lvl+1) >> BRIGHT_W; full level is the identity,
  // level zero is forced black since the formula alone would leave c>>BRIGHT_W.
  function automatic logic [CH_W-1:0] scale_f(input logic [CH_W-1:0]     c,
                                               input logic [BRIGHT_W-1:0] lvl);
    logic [BRIGHT_W:0] lvl_p1;
    logic [PROD_W-1:0] prod;
    lvl_p1 = {1'b0, lvl} + (BRIGHT_W+1)'(1);
    prod   = {{(BRIGHT_W+1){1'b0}}, c} * {{CH_W{1'b0}}, lvl_p1};
    if (lvl == '0) return '0;
    return prod[BRIGHT_W +: CH_W];
  endfunction

  state_t               state_q, state_d;
  logic [BRIGHT_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PIX_W-1:0]     col_p1_q, col_p1_d;
  logic                 vld_p1_q, vld_p1_d;
  logic [CH_W-1:0]      r_p2_q, r_p2_d;
  logic [CH_W-1:0]      g_p2_q, g_p2_d;
  logic [CH_W-1:0]      b_p2_q, b_p2_d;

  // ---- Stage 1: colour mode transform ----
  always_comb begin
    logic [CH_W-1:0] r, g, b, y;
    r = vga_out[PIX_W-1 -: CH_W];
    g = vga_out[2*CH_W-1 -: CH_W];
    b = vga_out[CH_W-1:0];
    y = gray_f(r, g, b);
    col_p1_d = vga_out;
    unique case (mode)
      2'b00:   col_p1_d = vga_out;
      2'b01:   col_p1_d = {y, y, y};
      2'b10:   col_p1_d = ~vga_out;
      default: col_p1_d = {b, g, r};
    endcase
    vld_p1_d = active;
  end

  // ---- Stage 2: brightness scale and blanking ----
  always_comb begin
    r_p2_d = '0;
    g_p2_d = '0;
    b_p2_d = '0;
    if (vld_p1_q) begin
      r_p2_d = scale_f(col_p1_q[PIX_W-1 -: CH_W], level_q);
      g_p2_d = scale_f(col_p1_q[2*CH_W-1 -: CH_W], level_q);
      b_p2_d = scale_f(col_p1_q[CH_W-1:0], level_q);
    end
  end

  // Fade FSM. A request that changes state pre-empts a coincident vsync step;
  // a request for the direction already in progress is not a transition.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ON: begin
        level_d = LMAX;
        if (fade_out) begin
          state_d = ST_FADE_OUT;
          cnt_d   = '0;
        end
      end
      ST_OFF: begin
        level_d = '0;
        if (fade_in && !fade_out) begin
          state_d = ST_FADE_IN;
          cnt_d   = '0;
        end
      end
      ST_FADE_OUT: begin
        if (fade_in && !fade_out) begin
          state_d = ST_FADE_IN;
          cnt_d   = '0;
        end else if (vsync_pulse) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = (level_q == '0) ? '0 : level_q - BRIGHT_W'(1);
            if (level_d == '0) state_d = ST_OFF;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (fade_out) begin
          state_d = ST_FADE_OUT;
          cnt_d   = '0;
        end else if (vsync_pulse) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = (level_q == LMAX) ? LMAX : level_q + BRIGHT_W'(1);
            if (level_d == LMAX) state_d = ST_ON;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q  <= ST_ON;
      level_q  <= LMAX;
      cnt_q    <= '0;
      vld_p1_q <= 1'b0;
      r_p2_q   <= '0;
      g_p2_q   <= '0;
      b_p2_q   <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      vld_p1_q <= vld_p1_d;
      r_p2_q   <= r_p2_d;
      g_p2_q   <= g_p2_d;
      b_p2_q   <= b_p2_d;
    end
  end

  // Stage-1 colour is gated by vld_p1_q downstream, so it needs no reset.
  always_ff @(posedge clk) begin
    col_p1_q <= col_p1_d;
  end

  assign VGA_R     = r_p2_q;
  assign VGA_G     = g_p2_q;
  assign VGA_B     = b_p2_q;
  assign level     = level_q;
  assign fade_busy = (state_q == ST_FADE_OUT) || (state_q == ST_FADE_IN);

endmodule

// File: tb/tb_vga_color_fade.sv
module tb_vga_color_fade;

  logic        clk = 1'b0;
  logic        RST;
  logic [11:0] vga_out;
  logic        active;
  logic [1:0]  mode;
  logic        vsync_pulse, fade_in, fade_out;
  logic [3:0]  VGA_R, VGA_G, VGA_B, level;
  logic        fade_busy;

  always #5 clk = ~clk;

  vga_color_fade #(.CH_W(4), .BRIGHT_W(4), .FADE_FRAMES(2)) dut (
    .clk(clk), .RST(RST), .vga_out(vga_out), .active(active), .mode(mode),
    .vsync_pulse(vsync_pulse), .fade_in(fade_in), .fade_out(fade_out),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .level(level), .fade_busy(fade_busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: fade phase as a name, level and frame count as integers,
  // stage-1 contents as plain channel values.
  string m_phase = "ON";
  int    m_level = 15;
  int    m_frames = 0;
  bit    m_p1_v = 0;
  int    m_p1_r = 0, m_p1_g = 0, m_p1_b = 0;
  int    m_r = 0, m_g = 0, m_b = 0;

  function automatic int scl(int c, int l);
    return (l == 0) ? 0 : (c * (l + 1)) / 16;
  endfunction

  task automatic model_edge();
    int r, g, b, y;
    if (!RST) begin
      m_phase = "ON"; m_level = 15; m_frames = 0; m_p1_v = 0;
      m_r = 0; m_g = 0; m_b = 0;
      return;
    end
    m_r = m_p1_v ? scl(m_p1_r, m_level) : 0;
    m_g = m_p1_v ? scl(m_p1_g, m_level) : 0;
    m_b = m_p1_v ? scl(m_p1_b, m_level) : 0;
    r = int'(vga_out[11:8]); g = int'(vga_out[7:4]); b = int'(vga_out[3:0]);
    y = (r + 2 * g + b) / 4;
    m_p1_v = active;
    case (mode)
      2'b00: begin m_p1_r = r;      m_p1_g = g;      m_p1_b = b;      end
      2'b01: begin m_p1_r = y;      m_p1_g = y;      m_p1_b = y;      end
      2'b10: begin m_p1_r = 15 - r; m_p1_g = 15 - g; m_p1_b = 15 - b; end
      default: begin m_p1_r = b;    m_p1_g = g;      m_p1_b = r;      end
    endcase
    if (m_phase == "ON") begin
      if (fade_out) begin m_phase = "FADE_OUT"; m_frames = 0; end
    end else if (m_phase == "OFF") begin
      if (fade_in && !fade_out) begin m_phase = "FADE_IN"; m_frames = 0; end
    end else if (m_phase == "FADE_OUT") begin
      if (fade_in && !fade_out) begin m_phase = "FADE_IN"; m_frames = 0; end
      else if (vsync_pulse) begin
        m_frames++;
        if (m_frames == 2) begin
          m_frames = 0;
          m_level = (m_level > 0) ? m_level - 1 : 0;
          if (m_level == 0) m_phase = "OFF";
        end
      end
    end else begin
      if (fade_out) begin m_phase = "FADE_OUT"; m_frames = 0; end
      else if (vsync_pulse) begin
        m_frames++;
        if (m_frames == 2) begin
          m_frames = 0;
          m_level = (m_level < 15) ? m_level + 1 : 15;
          if (m_level == 15) m_phase = "ON";
        end
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(string nm);
    chk({nm, ".R"}, int'(VGA_R), m_r);
    chk({nm, ".G"}, int'(VGA_G), m_g);
    chk({nm, ".B"}, int'(VGA_B), m_b);
    chk({nm, ".level"}, int'(level), m_level);
    chk({nm, ".busy"}, int'(fade_busy),
        int'(m_phase == "FADE_OUT" || m_phase == "FADE_IN"));
  endtask

  task automatic chk_rgb(string nm, int r, int g, int b);
    chk({nm, ".R"}, int'(VGA_R), r);
    chk({nm, ".G"}, int'(VGA_G), g);
    chk({nm, ".B"}, int'(VGA_B), b);
  endtask

  task automatic pulse();
    vsync_pulse = 1'b1; cyc();
    vsync_pulse = 1'b0; cyc();
  endtask

  typedef struct {
    logic [11:0] pix;
    logic        act;
    logic [1:0]  md;
    int          r, g, b;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{12'hF84, 1'b1, 2'b00, 15, 8, 4};
    vt[1] = '{12'hF84, 1'b0, 2'b00, 0, 0, 0};
    vt[2] = '{12'hF84, 1'b1, 2'b01, 8, 8, 8};
    vt[3] = '{12'hF84, 1'b1, 2'b10, 0, 7, 11};
    vt[4] = '{12'hF84, 1'b1, 2'b11, 4, 8, 15};
    vt[5] = '{12'h123, 1'b1, 2'b01, 2, 2, 2};
    vt[6] = '{12'hFFF, 1'b1, 2'b01, 15, 15, 15};
    vt[7] = '{12'h000, 1'b1, 2'b10, 15, 15, 15};
    vt[8] = '{12'h5A3, 1'b1, 2'b11, 3, 10, 5};

    // Reset held with every input busy
    RST = 1'b0; vga_out = 12'hFFF; active = 1'b1; mode = 2'b10;
    vsync_pulse = 1'b1; fade_in = 1'b1; fade_out = 1'b1;
    repeat (3) cyc();
    chk_rgb("reset", 0, 0, 0);
    chk("reset.level", int'(level), 15);
    chk("reset.busy", int'(fade_busy), 0);
    RST = 1'b1; vsync_pulse = 1'b0; fade_in = 1'b0; fade_out = 1'b0;

    // Colour modes at full brightness, two-cycle latency
    foreach (vt[i]) begin
      vga_out = vt[i].pix; active = vt[i].act; mode = vt[i].md;
      cyc();
      vga_out = 12'h000; active = 1'b0;
      cyc();
      chk_rgb($sformatf("mode_vec%0d", i), vt[i].r, vt[i].g, vt[i].b);
      chk_model($sformatf("mode_vec%0d_model", i));
    end

    // Full fade-out over 30 frame pulses
    vga_out = 12'hF84; active = 1'b1; mode = 2'b00;
    fade_out = 1'b1; cyc(); fade_out = 1'b0;
    chk("fo_start.level", int'(level), 15);
    chk("fo_start.busy", int'(fade_busy), 1);
    for (int i = 1; i <= 30; i++) begin
      pulse();
      chk($sformatf("fo_pulse%0d.level", i), int'(level), 15 - i / 2);
      chk($sformatf("fo_pulse%0d.busy", i), int'(fade_busy), int'(i < 30));
      if (i == 16) chk_rgb("fo_level7", 7, 4, 2);
    end
    repeat (3) pulse();
    chk("off_hold.level", int'(level), 0);
    chk_rgb("off_black", 0, 0, 0);

    // Fade in to 10, reverse, then simultaneous requests keep fading out
    fade_in = 1'b1; cyc(); fade_in = 1'b0;
    repeat (20) pulse();
    chk("fi_to10.level", int'(level), 10);
    fade_out = 1'b1; cyc(); fade_out = 1'b0;
    fade_in = 1'b1; fade_out = 1'b1; cyc(); fade_in = 1'b0; fade_out = 1'b0;
    chk("both.level", int'(level), 10);
    chk("both.busy", int'(fade_busy), 1);
    chk_model("both_model");
    fade_in = 1'b1; cyc(); fade_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      pulse();
      chk($sformatf("fi_pulse%0d.level", i), int'(level), 10 + i / 2);
    end
    chk("fi_done.busy", int'(fade_busy), 0);

    // Request coinciding with a frame pulse takes no step
    fade_out = 1'b1; vsync_pulse = 1'b1; cyc(); fade_out = 1'b0; vsync_pulse = 1'b0;
    pulse();
    chk("req_vsync.level", int'(level), 15);
    pulse();
    chk("req_vsync2.level", int'(level), 14);

    // Reset mid-fade at level 5
    repeat (18) pulse();
    chk("mid.level", int'(level), 5);
    RST = 1'b0; cyc(); RST = 1'b1;
    chk("mid_rst.level", int'(level), 15);
    chk("mid_rst.busy", int'(fade_busy), 0);
    chk_rgb("mid_rst", 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      RST         = ($urandom_range(0, 199) != 0);
      vga_out     = 12'($urandom);
      active      = 1'($urandom);
      mode        = 2'($urandom);
      vsync_pulse = ($urandom_range(0, 3) == 0);
      fade_in     = ($urandom_range(0, 39) == 0);
      fade_out    = ($urandom_range(0, 39) == 0);
      cyc();
      chk_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
